// File: rtl/neuron_sched_pkg.sv
// Shared types for the neuron update scheduler: sweep FSM states and model codes.
package neuron_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_LOAD = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4,
        ST_DONE = 3'd5
    } sched_state_t;

    // Model code 2'b11 is not named: it is passed through and the datapath treats it as LIF.
    localparam logic [1:0] MODEL_LIF  = 2'b00;
    localparam logic [1:0] MODEL_IZHI = 2'b01;
    localparam logic [1:0] MODEL_QLIF = 2'b10;

endpackage

// File: rtl/neuron_update_scheduler_spike_fifo.sv
// Synchronous FIFO carrying spiking neuron IDs toward the network interface.
// A push is refused while full even if a pop happens in the same cycle.
// DEPTH is expected to be a power of two, at least 2, so the pointers wrap naturally.
module spike_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head reads as zero when empty so the output is clean after reset.
    assign head    = empty ? '0 : storage[rd_ptr];

    // Entry storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/neuron_update_scheduler.sv
// Time-multiplexes one shared neuron potential-update datapath across NUM_NEURONS
// neurons: per timestep it walks the state memory in order, runs each neuron
// through the datapath, writes the new potential back and queues spiking IDs.
module neuron_update_scheduler
    import neuron_sched_pkg::*;
#(
    parameter int NUM_NEURONS = 16,
    parameter int ID_W        = $clog2(NUM_NEURONS),
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              timestep,
    input  logic [1:0]        model,
    output logic              mem_rd_en,
    output logic [ID_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0] mem_rd_pot,
    input  logic [DATA_W-1:0] mem_rd_wgt,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_pot,
    output logic              dp_start,
    output logic              dp_clear,
    output logic [1:0]        dp_model,
    output logic [DATA_W-1:0] dp_potential,
    output logic [DATA_W-1:0] dp_weight,
    input  logic              dp_done,
    input  logic [DATA_W-1:0] dp_final_potential,
    input  logic              dp_spike,
    output logic              spk_valid,
    output logic [ID_W-1:0]   spk_id,
    input  logic              spk_ready,
    output logic              busy,
    output logic              step_done,
    output logic              overrun
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_NEURONS - 1);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [ID_W-1:0]   index;
    logic              exec_first;
    logic [DATA_W-1:0] opnd_pot_p0;
    logic [DATA_W-1:0] opnd_wgt_p0;
    logic [DATA_W-1:0] res_pot_p1;
    logic              res_spike_p1;
    logic              fifo_full;
    logic              fifo_empty;
    logic              is_last;
    logic              wb_fire;
    logic              dp_result_vld;
    logic              spk_pop;

    assign is_last       = (index == LAST_IDX);
    // Write-back is held off only when a spike cannot be queued.
    assign wb_fire       = (state == ST_WB) && !(res_spike_p1 && fifo_full);
    // dp_done is ignored in the launch cycle; the datapath answers at least one cycle later.
    assign dp_result_vld = (state == ST_EXEC) && dp_done && !exec_first;
    assign spk_valid     = ~fifo_empty;
    assign spk_pop       = spk_valid & spk_ready;

    assign mem_rd_en    = (state == ST_READ);
    assign mem_wr_en    = wb_fire;
    assign mem_addr     = index;
    assign mem_wr_pot   = res_pot_p1;
    assign dp_start     = (state == ST_EXEC) && exec_first;
    assign dp_potential = opnd_pot_p0;
    assign dp_weight    = opnd_wgt_p0;
    assign busy         = (state != ST_IDLE);
    assign step_done    = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the per-neuron read/load/exec/write-back walk.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (timestep) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_EXEC;
            ST_EXEC: if (dp_result_vld) state_nxt = ST_WB;
            ST_WB:   if (wb_fire) state_nxt = is_last ? ST_DONE : ST_READ;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Sweep control: neuron index, launch marker, clear pulse, latched model, overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index      <= '0;
            exec_first <= 1'b0;
            dp_clear   <= 1'b0;
            dp_model   <= MODEL_LIF;
            overrun    <= 1'b0;
        end else begin
            exec_first <= (state == ST_LOAD);
            dp_clear   <= (state == ST_IDLE) && timestep;
            if (state == ST_IDLE && timestep) begin
                index    <= '0;
                dp_model <= model;
            end else if (wb_fire && !is_last) begin
                index <= index + 1'b1;
            end else if (state == ST_DONE) begin
                index <= '0;
            end
            if (timestep && state != ST_IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    // Stage p0: operands captured in LOAD, held through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_pot_p0 <= '0;
            opnd_wgt_p0 <= '0;
        end else if (state == ST_LOAD) begin
            opnd_pot_p0 <= mem_rd_pot;
            opnd_wgt_p0 <= mem_rd_wgt;
        end
    end

    // Stage p1: datapath result captured on dp_done, held through write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_pot_p1   <= '0;
            res_spike_p1 <= 1'b0;
        end else if (dp_result_vld) begin
            res_pot_p1   <= dp_final_potential;
            res_spike_p1 <= dp_spike;
        end
    end

    spike_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ID_W)
    ) u_spike_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wb_fire & res_spike_p1),
        .push_data (index),
        .pop       (spk_pop),
        .head      (spk_id),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Scoreboard bench for neuron_update_scheduler: behavioural state memory and
// datapath, expected write-backs and spike IDs queued at sweep start.
module tb_neuron_update_scheduler;

    localparam int NN  = 4;
    localparam int IDW = 2;
    localparam int DW  = 32;
    localparam int FD  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            timestep = 1'b0;
    logic [1:0]      model = 2'b00;
    logic            mem_rd_en;
    logic [IDW-1:0]  mem_addr;
    logic [DW-1:0]   mem_rd_pot = '0;
    logic [DW-1:0]   mem_rd_wgt = '0;
    logic            mem_wr_en;
    logic [DW-1:0]   mem_wr_pot;
    logic            dp_start;
    logic            dp_clear;
    logic [1:0]      dp_model;
    logic [DW-1:0]   dp_potential;
    logic [DW-1:0]   dp_weight;
    logic            dp_done = 1'b0;
    logic [DW-1:0]   dp_final_potential = '0;
    logic            dp_spike = 1'b0;
    logic            spk_valid;
    logic [IDW-1:0]  spk_id;
    logic            spk_ready = 1'b0;
    logic            busy;
    logic            step_done;
    logic            overrun;

    always #5 clk = ~clk;

    neuron_update_scheduler #(
        .NUM_NEURONS (NN),
        .ID_W        (IDW),
        .DATA_W      (DW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .timestep           (timestep),
        .model              (model),
        .mem_rd_en          (mem_rd_en),
        .mem_addr           (mem_addr),
        .mem_rd_pot         (mem_rd_pot),
        .mem_rd_wgt         (mem_rd_wgt),
        .mem_wr_en          (mem_wr_en),
        .mem_wr_pot         (mem_wr_pot),
        .dp_start           (dp_start),
        .dp_clear           (dp_clear),
        .dp_model           (dp_model),
        .dp_potential       (dp_potential),
        .dp_weight          (dp_weight),
        .dp_done            (dp_done),
        .dp_final_potential (dp_final_potential),
        .dp_spike           (dp_spike),
        .spk_valid          (spk_valid),
        .spk_id             (spk_id),
        .spk_ready          (spk_ready),
        .busy               (busy),
        .step_done          (step_done),
        .overrun            (overrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference contents of the state memory for the sweep being run.
    logic [DW-1:0] ref_pot [NN];
    logic [DW-1:0] ref_wgt [NN];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_spk[$];
    int  n_writes = 0;
    int  cur_lat = 1;

    // State memory: data shows up one cycle after the read strobe, junk otherwise.
    logic rd_pend = 1'b0;
    int   rd_addr = 0;
    always @(negedge clk) begin
        if (rd_pend) begin
            mem_rd_pot = ref_pot[rd_addr];
            mem_rd_wgt = ref_wgt[rd_addr];
        end else begin
            mem_rd_pot = $urandom;
            mem_rd_wgt = $urandom;
        end
        rd_pend = mem_rd_en;
        rd_addr = int'(mem_addr);
    end

    // Datapath: result = potential + weight after cur_lat cycles; spike when the weight is odd.
    int          wait_cnt = 0;
    logic [DW-1:0] held_pot = '0;
    logic [DW-1:0] held_wgt = '0;
    always @(negedge clk) begin
        dp_done = 1'b0;
        dp_final_potential = $urandom;
        dp_spike = 1'($urandom);
        if (!rst_n) begin
            wait_cnt = 0;
        end else if (dp_start) begin
            check("dp_start_single", 64'(wait_cnt), 64'd0);
            held_pot = dp_potential;
            held_wgt = dp_weight;
            wait_cnt = cur_lat;
        end else if (wait_cnt != 0) begin
            check("dp_potential_stable", dp_potential, held_pot);
            check("dp_weight_stable", dp_weight, held_wgt);
            wait_cnt--;
            if (wait_cnt == 0) begin
                dp_done = 1'b1;
                dp_final_potential = held_pot + held_wgt;
                dp_spike = held_wgt[0];
            end
        end
    end

    // Write-back monitor.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && mem_wr_en) begin
            n_writes++;
            if (exp_wr.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %0h, none expected", mem_addr, mem_wr_pot);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", mem_wr_pot, 64'(e.data));
            end
        end
    end

    // Spike output monitor.
    logic           prev_hold = 1'b0;
    logic [IDW-1:0] prev_id = '0;
    always @(negedge clk) begin
        int e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("spk_valid_held", spk_valid, 1);
                check("spk_id_stable", spk_id, prev_id);
            end
            if (spk_valid && spk_ready) begin
                if (exp_spk.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_spike: id %0d, none expected", spk_id);
                end else begin
                    e = exp_spk.pop_front();
                    check("spk_id", 64'(spk_id), 64'(e));
                end
            end
            prev_hold = spk_valid && !spk_ready;
            prev_id = spk_id;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0 random, 1 no spikes, 2 all spike, 3 neurons 1 and 3 spike with result 3F000000.
    task automatic load_mem(input int mode);
        logic [DW-1:0] w;
        for (int i = 0; i < NN; i++) begin
            w = $urandom;
            ref_pot[i] = $urandom;
            case (mode)
                1: w[0] = 1'b0;
                2: w[0] = 1'b1;
                3: begin
                    w[0] = (i == 1 || i == 3);
                    ref_pot[i] = 32'h3F000000 - w;
                end
                default: ;
            endcase
            ref_wgt[i] = w;
        end
    endtask

    task automatic push_expect();
        wr_t e;
        for (int i = 0; i < NN; i++) begin
            e.addr = i;
            e.data = ref_pot[i] + ref_wgt[i];
            exp_wr.push_back(e);
            if (ref_wgt[i][0]) exp_spk.push_back(i);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd_en"}, mem_rd_en, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wr_en"}, mem_wr_en, 0);
        check({tag, "_mem_wr_pot"}, mem_wr_pot, 0);
        check({tag, "_dp_start"}, dp_start, 0);
        check({tag, "_dp_clear"}, dp_clear, 0);
        check({tag, "_dp_model"}, dp_model, 0);
        check({tag, "_dp_potential"}, dp_potential, 0);
        check({tag, "_dp_weight"}, dp_weight, 0);
        check({tag, "_spk_valid"}, spk_valid, 0);
        check({tag, "_spk_id"}, spk_id, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_step_done"}, step_done, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    // One sweep with a fixed datapath latency; exp_cycles <= 0 skips the timing check.
    task automatic run_sweep(input int lat, input int exp_cycles, input bit rand_rdy, input bit inject_ovr);
        logic [1:0] m;
        int k;
        int starts;
        bit seen;
        m = 2'($urandom);
        starts = 0;
        seen = 0;
        cur_lat = lat;
        push_expect();
        timestep = 1'b1;
        model = m;
        for (k = 1; k <= 2000; k++) begin
            tick();
            if (k == 1) begin
                timestep = 1'b0;
                model = ~m;
                check("dp_clear_first", dp_clear, 1);
                check("busy_start", busy, 1);
                check("first_read", {mem_rd_en, 30'd0, mem_addr}, {1'b1, 30'd0, 2'd0});
            end
            if (k == 2) check("dp_clear_once", dp_clear, 0);
            if (inject_ovr && k == 3) timestep = 1'b1;
            if (inject_ovr && k == 4) timestep = 1'b0;
            if (rand_rdy) spk_ready = 1'($urandom);
            if (dp_start) starts++;
            if (step_done) begin
                seen = 1;
                break;
            end
        end
        check("step_done_seen", seen, 1);
        if (exp_cycles > 0) check("sweep_cycles", 64'(k), 64'(exp_cycles));
        check("dp_start_count", 64'(starts), 64'(NN));
        check("dp_model", dp_model, m);
        check("busy_in_done", busy, 1);
        tick();
        check("step_done_pulse", step_done, 0);
        check("busy_after", busy, 0);
        if (rand_rdy) spk_ready = 1'b1;
    endtask

    task automatic drain();
        spk_ready = 1'b1;
        for (int i = 0; i < 50 && exp_spk.size() != 0; i++) tick();
        tick();
        check("drain_spikes", 64'(exp_spk.size()), 0);
        check("drain_writes", 64'(exp_wr.size()), 0);
        check("drain_valid", spk_valid, 0);
    endtask

    initial begin
        int base;
        int k;
        int busy_cnt;
        bit seen;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Quiet sweep: no spikes, minimum latency.
        spk_ready = 1'b1;
        load_mem(1);
        run_sweep(1, 5 * NN + 1, 0, 0);
        check("quiet_no_spike", spk_valid, 0);
        drain();

        // Spike ordering: neurons 1 and 3.
        load_mem(3);
        run_sweep(1, 5 * NN + 1, 0, 0);
        drain();

        // Long datapath latency.
        load_mem(0);
        run_sweep(7, NN * 11 + 1, 0, 0);
        drain();

        // Overrun: second timestep mid-sweep is ignored.
        check("overrun_before", overrun, 0);
        load_mem(0);
        run_sweep(1, 5 * NN + 1, 0, 1);
        check("overrun_set", overrun, 1);
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) busy_cnt++;
        end
        check("overrun_no_second_sweep", 64'(busy_cnt), 0);
        check("overrun_sticky", overrun, 1);
        drain();

        // Back-pressure: every neuron spikes into a two-entry FIFO with no reader.
        spk_ready = 1'b0;
        load_mem(2);
        push_expect();
        cur_lat = 1;
        base = n_writes;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        for (k = 0; k < 200 && n_writes - base < 2; k++) tick();
        repeat (10) tick();
        check("bp_stall_writes", 64'(n_writes - base), 2);
        check("bp_stall_busy", busy, 1);
        check("bp_stall_no_wr", mem_wr_en, 0);
        check("bp_fifo_valid", spk_valid, 1);
        spk_ready = 1'b1;
        check("bp_pop_cycle_no_wr", mem_wr_en, 0);
        tick();
        spk_ready = 1'b0;
        check("bp_wr_after_pop", mem_wr_en, 1);
        check("bp_wr_addr", mem_addr, 2);
        repeat (10) tick();
        check("bp_second_stall", 64'(n_writes - base), 3);
        spk_ready = 1'b1;
        seen = 0;
        for (k = 0; k < 200; k++) begin
            tick();
            if (step_done) begin
                seen = 1;
                break;
            end
        end
        check("bp_step_done", seen, 1);
        drain();

        // Randomised sweeps with random latency and random reader back-pressure.
        for (int r = 0; r < 6; r++) begin
            load_mem(0);
            run_sweep(int'($urandom_range(1, 6)), 0, 1, 0);
            drain();
        end

        // Reset in the middle of EXEC abandons the sweep.
        load_mem(0);
        push_expect();
        cur_lat = 7;
        timestep = 1'b1;
        tick();
        timestep = 1'b0;
        for (k = 0; k < 50 && !dp_start; k++) tick();
        check("rst_reached_exec", dp_start, 1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_wr.delete();
        exp_spk.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", busy, 0);
        check("post_reset_no_wr", mem_wr_en, 0);
        load_mem(0);
        run_sweep(2, NN * 6 + 1, 0, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
